fpadd_vector_sequencer: RTL and testbench
=========================================

// Module: fpadd_vector_sequencer
// PURPOSE
//  Upstream operand source for the FP adder in the board-level system.
//  Steps through a fixed internal table of 4 operand pairs and drives them onto reg_A/reg_B.
//  Waits for the adder latency, then compares the adder's result against the expected sum.
//  Holds each vector for a dwell period so the 7-seg and LED outputs are readable.
//  Reports per-vector match, an error count, and an overall pass/done status.
// PARAMETERS
//  ADD_LATENCY   2           cycles from operand change to a valid adder result; must be >= 1
//  DWELL_CYCLES  50_000_000  cycles each vector is held after checking; must be >= 1
//  DWELL_W       26          width of the dwell counter; 2**DWELL_W must be > DWELL_CYCLES
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset (one clock; no other clock domains)
//  hold       in   1   level; 1 freezes the dwell counter (stays on current vector)
//  rerun      in   1   1-cycle pulse; honoured only in DONE; restarts the sequence
//  result     in   32  adder output (IEEE-754 single)
//  reg_A      out  32  operand A to adder (registered)
//  reg_B      out  32  operand B to adder (registered)
//  vec_index  out  2   index of the vector currently applied
//  match      out  1   1 = current vector's result matched; valid from CHECK through DWELL
//  err_count  out  3   number of mismatching vectors, saturates at 4
//  done       out  1   1 in DONE state
//  all_pass   out  1   done & (err_count==0)
// BEHAVIOUR
//  Vector table, fixed (A, B, expected):
//   0: 6b64b235 + 6ac49214 = 6ba37d9f
//   1: 3f800000 + 3f800000 = 40000000
//   2: 40000000 + 40400000 = 40a00000
//   3: 3f800000 + bf800000 = 00000000
//  Reset (reset=0, async):
//   - All outputs are 0; state = LOAD; idx = 0; counters are 0.
//   - Takes effect immediately from any state, including mid-WAIT or mid-DWELL.
//   - The sequence restarts at vector 0 after release.
//  FSM:
//   - LOAD (1 cycle): reg_A/reg_B <= table[idx]; vec_index <= idx; match <= 0; lat_cnt <= 0. Go to WAIT.
//   - WAIT: lat_cnt increments each cycle. Lasts exactly ADD_LATENCY+1 cycles, including one guard cycle.
//     Go to CHECK.
//   - CHECK (1 cycle): match <= (result == expected[idx]), exact 32-bit compare.
//     On mismatch, err_count <= min(err_count+1, 4). dwell_cnt <= 0. Go to DWELL.
//   - DWELL: dwell_cnt increments only when hold=0.
//     When dwell_cnt == DWELL_CYCLES-1 and hold=0:
//       - if idx==3, go to DONE;
//       - otherwise idx <= idx+1 and go to LOAD.
//   - DONE: done=1 and operands stay on the last vector.
//     rerun=1 -> idx <= 0, err_count <= 0, done <= 0, go to LOAD.
//  rerun is ignored outside DONE. hold is ignored outside DWELL.
//  Cycles per vector = ADD_LATENCY + 3 + DWELL_CYCLES (with hold=0).
//  reg_A/reg_B change only on the LOAD edge, so they are stable for the whole vector period.
//  match remains 0 during LOAD/WAIT of every vector. It keeps its value in DONE.
//  all_pass is a registered value, updated together with done.
// TESTING (ADD_LATENCY=2, DWELL_CYCLES=4, bench adder model = exact-sum table lookup, 2-cycle delay)
//  1. Reset release -> 1 cycle later reg_A=6b64b235, reg_B=6ac49214, vec_index=0;
//     during DWELL match=1.
//  2. Correct model, hold=0 -> done=1 exactly 36 cycles after reset release;
//     all_pass=1, err_count=0, reg_A=3f800000, reg_B=bf800000.
//  3. Model forces vector 2 result to 40a00001 -> match=0 during vector 2 DWELL;
//     final err_count=1, all_pass=0, done=1.
//  4. hold=1 for 10 cycles during vector 1 DWELL -> vec_index stays 1;
//     done is asserted 10 cycles later than in test 2.
//  5. reset=0 pulse during vector 2 WAIT -> outputs 0 immediately;
//     after release the sequence restarts at vector 0 and err_count=0.
//  6. rerun pulse in DONE -> next cycle state is LOAD, then vec_index=0, err_count=0, done=0;
//     a rerun pulse during DWELL has no effect.

Source files
------------

// File: rtl/fpadd_vector_sequencer.sv
// Operand sequencer for the board-level FP adder: applies four fixed operand pairs,
// checks each adder result after the pipeline latency and holds each vector for display.
module fpadd_vector_sequencer #(
   parameter int ADD_LATENCY  = 2,
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int DWELL_W      = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        rerun,
   input  logic [31:0] result,
   output logic [31:0] reg_A,
   output logic [31:0] reg_B,
   output logic [1:0]  vec_index,
   output logic        match,
   output logic [2:0]  err_count,
   output logic        done,
   output logic        all_pass,
   output logic [2:0]  dbg_state_o
);

   // Handshake: none. result is sampled once per vector, ADD_LATENCY+1 cycles after
   // the operands change; the extra cycle is a guard against a late adder output.

   localparam int LAT_W = $clog2(ADD_LATENCY + 1);
   localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(ADD_LATENCY);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_WAIT  = 3'd1,
      S_CHECK = 3'd2,
      S_DWELL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [1:0]         vec_q, vec_d;
   logic               match_q, match_d;
   logic [2:0]         err_q, err_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;

   function automatic logic [31:0] tab_a(input logic [1:0] i);
      case (i)
         2'd0:    tab_a = 32'h6b64b235;
         2'd1:    tab_a = 32'h3f800000;
         2'd2:    tab_a = 32'h40000000;
         default: tab_a = 32'h3f800000;
      endcase
   endfunction

   function automatic logic [31:0] tab_b(input logic [1:0] i);
      case (i)
         2'd0:    tab_b = 32'h6ac49214;
         2'd1:    tab_b = 32'h3f800000;
         2'd2:    tab_b = 32'h40400000;
         default: tab_b = 32'hbf800000;
      endcase
   endfunction

   function automatic logic [31:0] tab_sum(input logic [1:0] i);
      case (i)
         2'd0:    tab_sum = 32'h6ba37d9f;
         2'd1:    tab_sum = 32'h40000000;
         2'd2:    tab_sum = 32'h40a00000;
         default: tab_sum = 32'h00000000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      dwell_d = dwell_q;
      a_d     = a_q;
      b_d     = b_q;
      vec_d   = vec_q;
      match_d = match_q;
      err_d   = err_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         S_LOAD: begin
            a_d     = tab_a(idx_q);
            b_d     = tab_b(idx_q);
            vec_d   = idx_q;
            match_d = 1'b0;
            lat_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_CHECK;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_CHECK: begin
            match_d = (result == tab_sum(idx_q));
            if ((result != tab_sum(idx_q)) && (err_q != 3'd4)) begin
               err_d = err_q + 3'd1;
            end
            dwell_d = '0;
            state_d = S_DWELL;
         end
         S_DWELL: begin
            if (!hold) begin
               if (dwell_q == DWELL_LAST) begin
                  if (idx_q == 2'd3) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     pass_d  = (err_q == 3'd0);
                  end else begin
                     idx_d   = idx_q + 2'd1;
                     state_d = S_LOAD;
                  end
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (rerun) begin
               idx_d   = 2'd0;
               err_d   = 3'd0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
         idx_q   <= '0;
         lat_q   <= '0;
         dwell_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         vec_q   <= '0;
         match_q <= 1'b0;
         err_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         dwell_q <= dwell_d;
         a_q     <= a_d;
         b_q     <= b_d;
         vec_q   <= vec_d;
         match_q <= match_d;
         err_q   <= err_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign reg_A       = a_q;
   assign reg_B       = b_q;
   assign vec_index   = vec_q;
   assign match       = match_q;
   assign err_count   = err_q;
   assign done        = done_q;
   assign all_pass    = pass_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpadd_vector_sequencer.sv
// Directed bench for fpadd_vector_sequencer with a 2-cycle table-lookup adder model.
module tb_fpadd_vector_sequencer;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        rerun;
   logic [31:0] result;
   logic [31:0] reg_A;
   logic [31:0] reg_B;
   logic [1:0]  vec_index;
   logic        match;
   logic [2:0]  err_count;
   logic        done;
   logic        all_pass;
   logic [2:0]  dbg_state_o;

   int          checks;
   int          errors;
   int          fault_vec;
   logic [31:0] stage1;
   int          cyc;

   fpadd_vector_sequencer #(
      .ADD_LATENCY (2),
      .DWELL_CYCLES(4),
      .DWELL_W     (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .rerun      (rerun),
      .result     (result),
      .reg_A      (reg_A),
      .reg_B      (reg_B),
      .vec_index  (vec_index),
      .match      (match),
      .err_count  (err_count),
      .done       (done),
      .all_pass   (all_pass),
      .dbg_state_o(dbg_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adder model: exact sums by lookup, optional corrupted vector, two register stages.
   function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = 32'hdeadbeef;
      if (a == 32'h6b64b235 && b == 32'h6ac49214) s = 32'h6ba37d9f;
      if (a == 32'h3f800000 && b == 32'h3f800000) s = 32'h40000000;
      if (a == 32'h40000000 && b == 32'h40400000) s = 32'h40a00000;
      if (a == 32'h3f800000 && b == 32'hbf800000) s = 32'h00000000;
      if (fault_vec == 0 && a == 32'h6b64b235) s = s ^ 32'h1;
      if (fault_vec == 2 && a == 32'h40000000) s = s ^ 32'h1;
      return s;
   endfunction

   always @(posedge clk) begin
      stage1 <= model_sum(reg_A, reg_B);
      result <= stage1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      hold  = 1'b0;
      rerun = 1'b0;
      tick();
      tick();
      check("rst_reg_A", reg_A, 32'h0);
      check("rst_vec", {30'd0, vec_index}, 32'd0);
      check("rst_flags", {28'd0, match, done, all_pass, 1'b0}, 32'd0);
      check("rst_err", {29'd0, err_count}, 32'd0);
      reset = 1'b1;
      cyc = 0;
   endtask

   task automatic run_to_done();
      while (!done && cyc < 300) tick();
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      fault_vec = -1;
      cyc       = 0;
      reset     = 1'b0;
      hold      = 1'b0;
      rerun     = 1'b0;
      #2;

      // first vector and normal completion
      reset_dut();
      tick();
      check("t1_reg_A", reg_A, 32'h6b64b235);
      check("t1_reg_B", reg_B, 32'h6ac49214);
      check("t1_vec", {30'd0, vec_index}, 32'd0);
      check("t1_match_load", {31'd0, match}, 32'd0);
      repeat (4) tick();
      check("t1_state_dwell", {29'd0, dbg_state_o}, 32'd3);
      check("t1_match_dwell", {31'd0, match}, 32'd1);
      run_to_done();
      check("t2_done_cycle", cyc, 32'd36);
      check("t2_all_pass", {31'd0, all_pass}, 32'd1);
      check("t2_err", {29'd0, err_count}, 32'd0);
      check("t2_reg_A", reg_A, 32'h3f800000);
      check("t2_reg_B", reg_B, 32'hbf800000);
      check("t2_vec", {30'd0, vec_index}, 32'd3);

      // corrupted vector 2 result
      fault_vec = 2;
      reset_dut();
      repeat (24) tick();
      check("t3_vec", {30'd0, vec_index}, 32'd2);
      check("t3_state", {29'd0, dbg_state_o}, 32'd3);
      check("t3_match", {31'd0, match}, 32'd0);
      run_to_done();
      check("t3_err", {29'd0, err_count}, 32'd1);
      check("t3_all_pass", {31'd0, all_pass}, 32'd0);
      check("t3_done", {31'd0, done}, 32'd1);
      fault_vec = -1;

      // hold during vector 1 dwell
      reset_dut();
      repeat (15) tick();
      hold = 1'b1;
      repeat (10) tick();
      check("t4_vec_held", {30'd0, vec_index}, 32'd1);
      check("t4_state_held", {29'd0, dbg_state_o}, 32'd3);
      hold = 1'b0;
      run_to_done();
      check("t4_done_cycle", cyc, 32'd46);

      // asynchronous reset mid-WAIT of vector 2
      fault_vec = 0;
      reset_dut();
      repeat (20) tick();
      check("t5_pre_vec", {30'd0, vec_index}, 32'd2);
      check("t5_pre_state", {29'd0, dbg_state_o}, 32'd1);
      check("t5_pre_err", {29'd0, err_count}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_reg_A", reg_A, 32'h0);
      check("t5_async_err", {29'd0, err_count}, 32'd0);
      check("t5_async_state", {29'd0, dbg_state_o}, 32'd0);
      fault_vec = -1;
      tick();
      reset = 1'b1;
      cyc = 0;
      tick();
      check("t5_restart_reg_A", reg_A, 32'h6b64b235);
      check("t5_restart_vec", {30'd0, vec_index}, 32'd0);
      run_to_done();
      check("t5_done_cycle", cyc, 32'd36);
      check("t5_err", {29'd0, err_count}, 32'd0);

      // rerun from DONE, then a stray rerun during DWELL
      rerun = 1'b1;
      cyc = -1;
      tick();
      rerun = 1'b0;
      check("t6_state_load", {29'd0, dbg_state_o}, 32'd0);
      check("t6_done", {31'd0, done}, 32'd0);
      check("t6_err", {29'd0, err_count}, 32'd0);
      tick();
      check("t6_vec", {30'd0, vec_index}, 32'd0);
      check("t6_reg_A", reg_A, 32'h6b64b235);
      repeat (5) tick();
      rerun = 1'b1;
      tick();
      rerun = 1'b0;
      check("t6_dwell_ignore", {29'd0, dbg_state_o}, 32'd3);
      check("t6_dwell_vec", {30'd0, vec_index}, 32'd0);
      run_to_done();
      check("t6_done_cycle", cyc, 32'd36);
      check("t6_all_pass", {31'd0, all_pass}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
